// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences word and sub-word accesses to a
// 128-word data memory with combinational read data, including read-modify-write.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  DMWr,
    output logic [6:0]  dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [8:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] din_q, din_d;
    logic        accept;
    logic        unused_addr_hi;

    // Upper address bits are deliberately dropped: the address space wraps at 512 bytes.
    assign unused_addr_hi = ^req_addr[31:9];

    function automatic logic bad_request(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_WORD: return lane != 2'b00;
            SZ_HALF: return lane[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? word[31:16] : word[15:0];
        b = word[{lane, 3'b000} +: 8];
        case (size)
            SZ_HALF: return uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_BYTE: return uns ? {24'h000000, b} : {{24{b[7]}}, b};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = word;
        if (size == SZ_HALF) begin
            m[{lane[1], 4'b0000} +: 16] = wdata;
        end else begin
            m[{lane, 3'b000} +: 8] = wdata[7:0];
        end
        return m;
    endfunction

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign DMWr      = ((state_q == WRITE) && !rst) ? 2'b01 : 2'b00;
    assign dm_addr   = addr_q[8:2];
    assign dm_din    = din_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[8:0];
                    wdata_d = req_wdata[15:0];
                    if (bad_request(req_size, req_addr[1:0])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (req_we && req_size == SZ_WORD) begin
                        state_d = WRITE;
                        din_d   = req_wdata;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Sub-word stores reuse READ to fetch the word they will merge into.
                if (we_q) begin
                    din_d   = store_merge(dm_dout, wdata_q, size_q, addr_q[1:0]);
                    state_d = WRITE;
                end else begin
                    rdata_d = load_extract(dm_dout, size_q, addr_q[1:0], uns_q);
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WRITE: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 9'h000;
            wdata_q <= 16'h0000;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            din_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            din_q   <= din_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: word-array data memory plus a byte-addressed reference
// model; directed scenarios followed by randomized traffic.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  DMWr;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;

    logic [31:0] mem [0:127];
    logic        pre_we;
    logic [6:0]  pre_idx;
    logic [31:0] pre_data;
    logic [7:0]  rb [0:511];

    int errs = 0;
    int checks = 0;
    int accepts = 0;
    int rsp_cnt = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .DMWr(DMWr), .dm_addr(dm_addr),
        .dm_din(dm_din), .dm_dout(dm_dout)
    );

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (DMWr == 2'b01) mem[dm_addr] <= dm_din;
        if (!rst && req_valid && req_ready) accepts <= accepts + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
    endfunction

    // Reference: byte-addressed memory, little-endian, from the access rules.
    task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] exp_rd, output logic exp_err,
                              output int exp_lat, output int exp_nw, output logic [31:0] exp_wd);
        int a, n;
        logic [15:0] h;
        logic [7:0] b;
        a = int'(addr & 32'h1FF);
        n = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
        exp_err = (size == 2'b11) || (a % n != 0);
        exp_rd = 32'h0; exp_lat = 1; exp_nw = 0; exp_wd = 32'h0;
        if (exp_err) return;
        if (!we) begin
            exp_lat = 2;
            h = {rb[a+1 > 511 ? 511 : a+1], rb[a]};
            b = rb[a];
            if (n == 4) exp_rd = ref_word(a / 4);
            else if (n == 2) exp_rd = uns ? {16'h0, h} : {{16{h[15]}}, h};
            else exp_rd = uns ? {24'h0, b} : {{24{b[7]}}, b};
        end else begin
            for (int i = 0; i < n; i++) rb[a+i] = wdata[8*i +: 8];
            exp_lat = (n == 4) ? 2 : 3;
            exp_nw = 1;
            exp_wd = ref_word(a / 4);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic [31:0] wd);
        logic [31:0] exp_rd, exp_wd;
        logic exp_err;
        int exp_lat, exp_nw, lat, nw, w;
        logic bad;
        logic [6:0] waddr;
        ref_access(we, size, uns, addr, wdata, exp_rd, exp_err, exp_lat, exp_nw, exp_wd);
        @(negedge clk);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        check("ready_before_accept", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nw = 0; bad = 1'b0; wd = 32'h0; waddr = 7'h0;
        while (!rsp_valid && lat < 8) begin
            if (DMWr == 2'b01) begin nw++; wd = dm_din; waddr = dm_addr; end
            if (DMWr[1]) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("write_cycles", nw, exp_nw);
        check("dmwr_code_legal", bad, 1'b0);
        if (exp_nw == 1) begin
            check("dm_din", wd, exp_wd);
            check("dm_addr_write", waddr, addr[8:2]);
        end
        rd = rsp_rdata;
        @(posedge clk); #1;
        check("rsp_one_cycle", rsp_valid, 1'b0);
        check("rsp_rdata_hold", rsp_rdata, rd);
        check("ready_after_rsp", req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wd, r32, a32, wdr;
        logic [1:0] sz;
        logic we, un;
        int acc0, rc0, n, last_cyc, cyc;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_idx = 7'h0; pre_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_dm_addr", dm_addr, 7'h0);
        check("rst_dm_din", dm_din, 32'h0);
        check("rst_DMWr", DMWr, 2'b00);
        check("rst_req_ready", req_ready, 1'b0);

        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            r32 = $urandom;
            pre_we = 1'b1; pre_idx = 7'(i); pre_data = r32;
            {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]} = r32;
        end
        @(negedge clk);
        pre_we = 1'b0;
        rst = 1'b0;

        // Word store then word load at 0x10
        do_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, rd, wd);
        check("sw10_din", wd, 32'hDEADBEEF);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, wd);
        check("lw10_rdata", rd, 32'hDEADBEEF);

        // Byte store merge
        do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'h55, rd, wd);
        check("sb12_din", wd, 32'hDE55BEEF);

        // Load extraction and extension
        do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h80F17F00, rd, wd);
        do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, rd, wd);
        check("lb21", rd, 32'h0000007F);
        do_req(1'b0, 2'b10, 1'b0, 32'h23, 32'h0, rd, wd);
        check("lb23", rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b10, 1'b1, 32'h23, 32'h0, rd, wd);
        check("lbu23", rd, 32'h00000080);
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, wd);
        check("lh22", rd, 32'hFFFF80F1);
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, wd);
        check("lhu22", rd, 32'h000080F1);
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, rd, wd);
        check("sh22_din", wd, 32'hABCD7F00);

        // Error cases
        do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, wd);
        check("err_lh11_rdata", rd, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFFF, rd, wd);
        check("err_sw12_rdata", rd, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, wd);
        check("err_size3_rdata", rd, 32'h0);

        // Reset during the WRITE of a byte store
        rc0 = rsp_cnt;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h13; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rmw_write_before_rst", DMWr, 2'b01);
        rst = 1'b1;
        #1;
        check("rst_mid_DMWr", DMWr, 2'b00);
        check("rst_mid_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_release_ready", req_ready, 1'b1);
        check("rst_release_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        check("rst_no_rsp_valid", rsp_valid, 1'b0);
        check("rst_no_rsp_count", rsp_cnt - rc0, 0);
        check("rst_mem_unchanged", mem[4], 32'hDE55BEEF);
        do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, wd);
        check("rst_reload", rd, 32'hDE55BEEF);

        // Back-to-back loads with req_valid held; address wraps
        acc0 = accepts; n = 0; last_cyc = 0;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h00000210;
        req_valid = 1'b1;
        for (cyc = 1; cyc <= 30 && n < 3; cyc++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                n++;
                check("b2b_rdata", rsp_rdata, ref_word(4));
                check("b2b_dm_addr", dm_addr, 7'd4);
                if (n > 1) check("b2b_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_responses", n, 3);
        check("b2b_accepts", accepts - acc0, 3);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            a32 = $urandom;
            if ($urandom_range(0, 1) == 1) a32[1:0] = 2'b00;
            wdr = $urandom;
            do_req(we, sz, un, a32, wdr, rd, wd);
        end

        for (int i = 0; i < 128; i++) check("final_mem", mem[i], ref_word(i));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req_valid  input  1  CPU load/store request present.
REQ-004 SHALL have port: req_ready  output  1  block can accept a request.
REQ-005 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_size  input  2  00 word, 01 halfword, 10 byte, 11 illegal.
REQ-007 SHALL have port: req_unsigned  input  1  loads only: 1 zero-extend, 0 sign-extend.
REQ-008 SHALL have port: req_addr  input  32  byte address; only bits [8:0] are used.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-justified for byte/half.
REQ-010 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 SHALL have port: rsp_err  output  1  misaligned or illegal-size request; valid with rsp_valid.
REQ-013 SHALL have port: DMWr  output  2  data-memory write code (00 none, 01 full word).
REQ-014 SHALL have port: dm_addr  output  7  word index, equal to latched addr[8:2].
REQ-015 SHALL have port: dm_din  output  32  word written to data memory.
REQ-016 SHALL have port: dm_dout  input  32  combinational (same-cycle) read data from memory.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE and not in reset.
REQ-018 SHALL accept on a rising edge with req_valid & req_ready; latch we, size, unsigned, addr[8:0], wdata.
REQ-019 SHALL flag error when size = 11, when size = 01 and addr[0] = 1, or when size = 00 and addr[1:0] != 00.
REQ-020 SHALL, on an error, go IDLE -> RESP with no memory access; rsp_err = 1 and rsp_rdata = 0.
REQ-021 SHALL, on a load, go IDLE -> READ -> RESP, registering the extracted data at the READ->RESP edge.
REQ-022 SHALL, on a word store, go IDLE -> WRITE -> RESP with dm_din = wdata.
REQ-023 SHALL, on a byte or half store, go IDLE -> READ (sample dm_dout) -> WRITE (merged word) -> RESP.
REQ-024 SHALL use little-endian lanes: byte k = bits [8k+7:8k]; a half at addr[1] = h occupies bits [16h+15:16h].
REQ-025 SHALL, in the merge, replace only the addressed lane with wdata[7:0] or wdata[15:0] and keep all other bits from the sampled word.
REQ-026 SHALL, on a load, right-justify the addressed lane, then sign- or zero-extend it per unsigned; word loads pass through unchanged.
REQ-027 SHALL drive DMWr = 01 only in WRITE and 00 in all other states; DMWr SHALL never be 10 or 11.
REQ-028 SHALL drive DMWr = 00 whenever rst = 1, regardless of state.
REQ-029 SHALL assert rsp_valid for exactly the one RESP cycle, then return to IDLE; rsp_rdata and rsp_err hold until the next RESP.
REQ-030 SHALL have latencies from the accept edge to rsp_valid high: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-031 SHALL ignore req_valid outside IDLE; the requester holds the request until it is accepted.
REQ-032 SHALL ignore req_addr[31:9] (address wraps modulo 512 bytes).

Reset
REQ-033 SHALL, on rst, force state IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, dm_addr = 0, dm_din = 0.
REQ-034 SHALL, on rst in mid-operation (READ/WRITE/RESP), abandon the request with no write and no response; req_ready = 1 from the first cycle after rst deasserts.

Verification
REQ-035 SHALL verify: word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> one DMWr = 01 cycle with dm_addr = 4, then rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-036 SHALL verify: mem[0x10] = 0xDEADBEEF, byte store 0x55 to addr 0x12 -> dm_din = 0xDE55BEEF in WRITE, rsp_valid 3 cycles after accept.
REQ-037 SHALL verify: mem word = 0x80F17F00; lb addr+1 -> 0x0000007F; lb addr+3 -> 0xFFFFFF80; lbu addr+3 -> 0x00000080; lh addr+2 -> 0xFFFF80F1; lhu addr+2 -> 0x000080F1.
REQ-038 SHALL verify: half load at addr 0x11, word store at addr 0x12, and size 11 -> rsp_err = 1, rsp_rdata = 0, DMWr stays 00, 1-cycle latency.
REQ-039 SHALL verify: rst pulsed during WRITE of a byte store -> DMWr = 00 in that cycle, memory unchanged, no rsp_valid, req_ready = 1 after release.
REQ-040 SHALL verify: back-to-back requests with req_valid held high -> each accepted only in IDLE; req_addr 0x00000210 accesses dm_addr = 4.
